// File: rtl/mips_mc_ctrl.sv
// Multi-cycle main control FSM for the MIPS datapath.
// Sequences each instruction through fetch, decode, execute, memory and writeback.
// It produces the {Select, Op} code for ControlALU, plus the register-file, PC, IR
// and memory-handshake strobes.
// Optional feature: define CTRL_PERF_EN to add the retired-instruction counter port.
module mips_mc_ctrl #(
    parameter int unsigned ILLEGAL_HALT = 0,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [31:0]      Instr,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             BranchTaken,
    input  logic             Zero,
    output logic [5:0]       Select,
    output logic             Op,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             MemToReg,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             dmem_byte,
    input  logic             dmem_ack,
    output logic             Illegal,
    output logic             Halted
`ifdef CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] retired
`endif
);

    typedef enum logic [2:0] {
        StFetch, StDecode, StExec, StMem, StWb, StHalt
    } state_e;

    typedef enum logic [2:0] {
        KindNop, KindRtype, KindIalu, KindBeq, KindBne, KindLoad, KindStore, KindIllegal
    } kind_e;

    state_e      state;
    kind_e       kind;
    logic        byte_op;

    kind_e       dec_kind;
    logic        dec_byte;
    logic [5:0]  dec_select;
    logic        dec_op;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        fetch_ack;
    logic        unused_instr;

    assign opcode       = Instr[31:26];
    assign funct        = Instr[5:0];
    assign unused_instr = ^Instr[25:6];

    // Classify the instruction word while it is presented with imem_ack, so the
    // class is already registered when DECODE begins.
    always_comb begin
        dec_kind = KindIllegal;
        dec_byte = 1'b0;
        case (opcode)
            6'h00: begin
                if (funct == 6'h00) begin
                    dec_kind = KindNop;
                end else if (funct == 6'h20 || funct == 6'h22 || funct == 6'h24 ||
                             funct == 6'h25 || funct == 6'h26 || funct == 6'h2A) begin
                    dec_kind = KindRtype;
                end
            end
            6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0A: dec_kind = KindIalu;
            6'h04: dec_kind = KindBeq;
            6'h05: dec_kind = KindBne;
            6'h23: dec_kind = KindLoad;
            6'h20: begin
                dec_kind = KindLoad;
                dec_byte = 1'b1;
            end
            6'h2B: dec_kind = KindStore;
            6'h28: begin
                dec_kind = KindStore;
                dec_byte = 1'b1;
            end
            default: dec_kind = KindIllegal;
        endcase
        if (dec_kind == KindRtype) begin
            dec_select = funct;
        end else if (dec_kind == KindNop) begin
            dec_select = 6'h00;
        end else begin
            dec_select = opcode;
        end
        dec_op = (dec_kind != KindRtype);
    end

    // Same-cycle strobes: IR/PC latch on the fetch ack, branch resolves in EXEC.
    always_comb begin
        fetch_ack   = (state == StFetch) && imem_req && imem_ack;
        IRWrite     = fetch_ack;
        PCWrite     = fetch_ack;
        BranchTaken = (state == StExec) &&
                      (((kind == KindBeq) && Zero) || ((kind == KindBne) && !Zero));
    end

    // Main sequencer with registered state-derived outputs.
    // Entering FETCH from another state raises imem_req together with the state, so
    // only the first FETCH after reset spends one idle cycle with the request low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StFetch;
            kind      <= KindNop;
            byte_op   <= 1'b0;
            imem_req  <= 1'b0;
            Select    <= 6'h00;
            Op        <= 1'b1;
            RegDst    <= 1'b0;
            RegWrite  <= 1'b0;
            MemToReg  <= 1'b0;
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            dmem_byte <= 1'b0;
            Illegal   <= 1'b0;
            Halted    <= 1'b0;
        end else begin
            Illegal  <= 1'b0;
            RegWrite <= 1'b0;
            RegDst   <= 1'b0;
            MemToReg <= 1'b0;
            unique case (state)
                StFetch: begin
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        imem_req <= 1'b0;
                        kind     <= dec_kind;
                        byte_op  <= dec_byte;
                        Select   <= dec_select;
                        Op       <= dec_op;
                        Illegal  <= (dec_kind == KindIllegal);
                        state    <= StDecode;
                    end
                end
                StDecode: begin
                    if (kind == KindIllegal) begin
                        Select <= 6'h00;
                        Op     <= 1'b1;
                        if (ILLEGAL_HALT != 0) begin
                            state  <= StHalt;
                            Halted <= 1'b1;
                        end else begin
                            state    <= StFetch;
                            imem_req <= 1'b1;
                        end
                    end else begin
                        state <= StExec;
                    end
                end
                StExec: begin
                    case (kind)
                        KindRtype, KindIalu: begin
                            state    <= StWb;
                            RegWrite <= 1'b1;
                            RegDst   <= (kind == KindRtype);
                        end
                        KindLoad, KindStore: begin
                            state     <= StMem;
                            dmem_req  <= 1'b1;
                            dmem_we   <= (kind == KindStore);
                            dmem_byte <= byte_op;
                        end
                        default: begin
                            state    <= StFetch;
                            imem_req <= 1'b1;
                            Select   <= 6'h00;
                            Op       <= 1'b1;
                        end
                    endcase
                end
                StMem: begin
                    if (dmem_ack) begin
                        dmem_req  <= 1'b0;
                        dmem_we   <= 1'b0;
                        dmem_byte <= 1'b0;
                        if (kind == KindStore) begin
                            state    <= StFetch;
                            imem_req <= 1'b1;
                            Select   <= 6'h00;
                            Op       <= 1'b1;
                        end else begin
                            state    <= StWb;
                            RegWrite <= 1'b1;
                            MemToReg <= 1'b1;
                        end
                    end
                end
                StWb: begin
                    state    <= StFetch;
                    imem_req <= 1'b1;
                    Select   <= 6'h00;
                    Op       <= 1'b1;
                end
                StHalt: begin
                    state <= StHalt;
                end
                default: begin
                    state    <= StFetch;
                    imem_req <= 1'b1;
                end
            endcase
        end
    end

`ifdef CTRL_PERF_EN
    logic retire_now;

    // Retiring transitions back to FETCH; illegal encodings never retire.
    always_comb begin
        retire_now = ((state == StExec) &&
                      (kind == KindNop || kind == KindBeq || kind == KindBne)) ||
                     ((state == StMem) && dmem_ack && (kind == KindStore)) ||
                     (state == StWb);
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired <= '0;
        end else if (retire_now) begin
            retired <= retired + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: one instance continues past illegal encodings,
// a second one halts on them. Both share the same stimulus.
module tb_mips_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_ack;
    logic [31:0] Instr;
    logic        Zero;
    logic        dmem_ack;

    logic        imem_req, IRWrite, PCWrite, BranchTaken, Op, RegDst, RegWrite, MemToReg;
    logic        dmem_req, dmem_we, dmem_byte, Illegal, Halted;
    logic [5:0]  Select;

    logic        h_imem_req, h_IRWrite, h_PCWrite, h_BranchTaken, h_Op, h_RegDst;
    logic        h_RegWrite, h_MemToReg, h_dmem_req, h_dmem_we, h_dmem_byte;
    logic        h_Illegal, h_Halted;
    logic [5:0]  h_Select;
`ifdef CTRL_PERF_EN
    logic [3:0]  retired;
    logic [31:0] h_retired;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mips_mc_ctrl #(.ILLEGAL_HALT(0), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_ack(imem_ack), .Instr(Instr),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .BranchTaken(BranchTaken), .Zero(Zero),
        .Select(Select), .Op(Op), .RegDst(RegDst), .RegWrite(RegWrite),
        .MemToReg(MemToReg), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_byte(dmem_byte), .dmem_ack(dmem_ack), .Illegal(Illegal), .Halted(Halted)
`ifdef CTRL_PERF_EN
        , .retired(retired)
`endif
    );

    mips_mc_ctrl #(.ILLEGAL_HALT(1), .CNT_W(32)) dut_h (
        .clk(clk), .reset(reset), .imem_req(h_imem_req), .imem_ack(imem_ack), .Instr(Instr),
        .IRWrite(h_IRWrite), .PCWrite(h_PCWrite), .BranchTaken(h_BranchTaken), .Zero(Zero),
        .Select(h_Select), .Op(h_Op), .RegDst(h_RegDst), .RegWrite(h_RegWrite),
        .MemToReg(h_MemToReg), .dmem_req(h_dmem_req), .dmem_we(h_dmem_we),
        .dmem_byte(h_dmem_byte), .dmem_ack(dmem_ack), .Illegal(h_Illegal),
        .Halted(h_Halted)
`ifdef CTRL_PERF_EN
        , .retired(h_retired)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) at negedges until the fetch request is up.
    task automatic wait_ireq();
        int n = 0;
        while (imem_req !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        check_eq("ireq_wait", imem_req, 1'b1);
    endtask

    // Present an instruction with an immediate ack; returns at the DECODE negedge.
    task automatic do_fetch(input logic [31:0] w);
        imem_ack = 1'b1;
        Instr    = w;
        #1;
        check_eq("fetch_irwrite", IRWrite, 1'b1);
        check_eq("fetch_pcwrite", PCWrite, 1'b1);
        @(negedge clk);
        imem_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; imem_ack = 1'b0; Instr = 32'h0; Zero = 1'b0; dmem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_imem_req", imem_req, 1'b0);
        check_eq("rst_select", Select, 6'h00);
        check_eq("rst_op", Op, 1'b1);
        check_eq("rst_regwrite", RegWrite, 1'b0);
        check_eq("rst_dmem_req", dmem_req, 1'b0);
        check_eq("rst_halted", h_Halted, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        wait_ireq();

        // ADD with a stray imem_ack during DECODE
        do_fetch(32'h01095020);
        check_eq("add_dec_select", Select, 6'h20);
        check_eq("add_dec_op", Op, 1'b0);
        check_eq("add_dec_illegal", Illegal, 1'b0);
        imem_ack = 1'b1;
        #1;
        check_eq("add_stray_ack", IRWrite, 1'b0);
        @(negedge clk);
        imem_ack = 1'b0;
        check_eq("add_exe_select", Select, 6'h20);
        check_eq("add_exe_op", Op, 1'b0);
        check_eq("add_exe_regwrite", RegWrite, 1'b0);
        @(negedge clk);
        check_eq("add_wb_regwrite", RegWrite, 1'b1);
        check_eq("add_wb_regdst", RegDst, 1'b1);
        check_eq("add_wb_memtoreg", MemToReg, 1'b0);
        @(negedge clk);
        check_eq("add_c5_imem_req", imem_req, 1'b1);
        check_eq("add_c5_regwrite", RegWrite, 1'b0);
        check_eq("add_c5_select", Select, 6'h00);
        check_eq("add_c5_op", Op, 1'b1);

        // LW, dmem_ack also asserted during the fetch ack, then 3 wait cycles in MEM
        dmem_ack = 1'b1;
        do_fetch(32'h8D090004);
        dmem_ack = 1'b0;
        check_eq("lw_dec_select", Select, 6'h23);
        check_eq("lw_dec_op", Op, 1'b1);
        check_eq("lw_dec_dmem_req", dmem_req, 1'b0);
        @(negedge clk);
        check_eq("lw_exe_select", Select, 6'h23);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("lw_mem_dmem_req", dmem_req, 1'b1);
            check_eq("lw_mem_dmem_we", dmem_we, 1'b0);
            check_eq("lw_mem_regwrite", RegWrite, 1'b0);
            if (i == 3) dmem_ack = 1'b1;
        end
        @(negedge clk);
        dmem_ack = 1'b0;
        check_eq("lw_wb_regwrite", RegWrite, 1'b1);
        check_eq("lw_wb_memtoreg", MemToReg, 1'b1);
        check_eq("lw_wb_regdst", RegDst, 1'b0);
        check_eq("lw_wb_dmem_req", dmem_req, 1'b0);
        @(negedge clk);
        check_eq("lw_done_imem_req", imem_req, 1'b1);

        // BEQ: both Zero values in EXEC
        do_fetch(32'h11090003);
        check_eq("beq_dec_select", Select, 6'h04);
        Zero = 1'b1;
        #1;
        check_eq("beq_dec_no_branch", BranchTaken, 1'b0);
        @(negedge clk);
        #1;
        check_eq("beq_z1_taken", BranchTaken, 1'b1);
        Zero = 1'b0;
        #1;
        check_eq("beq_z0_taken", BranchTaken, 1'b0);
        @(negedge clk);
        check_eq("beq_done_imem_req", imem_req, 1'b1);
        check_eq("beq_done_regwrite", RegWrite, 1'b0);

        // BNE inverts
        do_fetch(32'h15090003);
        check_eq("bne_dec_select", Select, 6'h05);
        @(negedge clk);
        Zero = 1'b1;
        #1;
        check_eq("bne_z1_taken", BranchTaken, 1'b0);
        Zero = 1'b0;
        #1;
        check_eq("bne_z0_taken", BranchTaken, 1'b1);
        @(negedge clk);
        check_eq("bne_done_imem_req", imem_req, 1'b1);

        // SB: store byte, zero-wait ack, retires from MEM
        do_fetch(32'hA1090000);
        check_eq("sb_dec_select", Select, 6'h28);
        @(negedge clk);
        @(negedge clk);
        check_eq("sb_mem_dmem_req", dmem_req, 1'b1);
        check_eq("sb_mem_dmem_we", dmem_we, 1'b1);
        check_eq("sb_mem_dmem_byte", dmem_byte, 1'b1);
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        check_eq("sb_done_imem_req", imem_req, 1'b1);
        check_eq("sb_done_dmem_req", dmem_req, 1'b0);
        check_eq("sb_done_regwrite", RegWrite, 1'b0);

        // Illegal opcode 0x3F
        do_fetch(32'hFC000000);
        check_eq("ill_dec_illegal", Illegal, 1'b1);
        check_eq("ill_dec_illegal_h", h_Illegal, 1'b1);
        @(negedge clk);
        check_eq("ill_next_illegal", Illegal, 1'b0);
        check_eq("ill_next_imem_req", imem_req, 1'b1);
        check_eq("ill_next_regwrite", RegWrite, 1'b0);
        check_eq("ill_next_halted", Halted, 1'b0);
        check_eq("ill_h_halted", h_Halted, 1'b1);
        check_eq("ill_h_imem_req", h_imem_req, 1'b0);
        check_eq("ill_h_select", h_Select, 6'h00);
        imem_ack = 1'b1;
        Instr    = 32'h0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            check_eq("halt_imem_req", h_imem_req, 1'b0);
            check_eq("halt_irwrite", h_IRWrite, 1'b0);
            check_eq("halt_halted", h_Halted, 1'b1);
        end
        imem_ack = 1'b0;

        // Reset releases HALT
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst2_halted", h_Halted, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst2_h_imem_req", h_imem_req, 1'b1);
        wait_ireq();

        // Reset while waiting in MEM; a late dmem_ack must be ignored
        do_fetch(32'h8D090004);
        @(negedge clk);
        @(negedge clk);
        check_eq("rmem_dmem_req", dmem_req, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rmem_after_dmem_req", dmem_req, 1'b0);
        check_eq("rmem_after_imem_req", imem_req, 1'b0);
        check_eq("rmem_after_select", Select, 6'h00);
        check_eq("rmem_after_op", Op, 1'b1);
        reset    = 1'b0;
        dmem_ack = 1'b1;
        @(negedge clk);
        check_eq("rmem_late_dmem_req", dmem_req, 1'b0);
        check_eq("rmem_late_regwrite", RegWrite, 1'b0);
        check_eq("rmem_late_imem_req", imem_req, 1'b1);
        dmem_ack = 1'b0;
        @(negedge clk);
        check_eq("rmem_idle_regwrite", RegWrite, 1'b0);
        check_eq("rmem_idle_imem_req", imem_req, 1'b1);

`ifdef CTRL_PERF_EN
        // 17 NOPs on a 4-bit counter wrap to 1
        reset = 1'b1;
        @(negedge clk);
        check_eq("perf_rst", retired, 4'h0);
        reset = 1'b0;
        for (int i = 0; i < 17; i++) begin
            wait_ireq();
            do_fetch(32'h0);
            @(negedge clk);
            @(negedge clk);
        end
        check_eq("perf_wrap", retired, 4'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
